// File: rtl/dsp_pkg.sv
`timescale 1ns/1ps
// dsp_pkg
// Shared definitions for the chorus/flanger DSP blocks.
//   lfo_state_t : LFO controller states (IDLE, ADVANCE, MULT, DONE)
//   TRI_OFFSET  : bias removed from the 0..32767 triangle to make it bipolar
//   TRI_SHIFT   : right shift that scales bi*depth back to samples of delay
//   TRI_BITS    : number of phase bits folded into the triangle
package dsp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ADVANCE = 2'd1,
    MULT    = 2'd2,
    DONE    = 2'd3
  } lfo_state_t;

  localparam int TRI_OFFSET = 16384;
  localparam int TRI_SHIFT  = 14;
  localparam int TRI_BITS   = 15;

endpackage

// File: rtl/lfo_shift_add_mult.sv
`timescale 1ns/1ps
// lfo_shift_add_mult
// Sequential signed-by-unsigned shift-add multiplier. A start pulse loads the
// operands; one multiplier bit (LSB first) is consumed per clock, so the
// product is final DEPTH_WIDTH clocks after start, when done pulses for one
// cycle. The product then holds until the next start.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : load operands and begin
//   multiplicand  : signed 16-bit operand
//   multiplier    : unsigned DEPTH_WIDTH-bit operand
//   done          : one-cycle pulse, product valid
//   product       : signed (16+DEPTH_WIDTH)-bit result
module lfo_shift_add_mult #(
  parameter int DEPTH_WIDTH = 10
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic signed [15:0]              multiplicand,
  input  logic        [DEPTH_WIDTH-1:0]   multiplier,
  output logic                            done,
  output logic signed [16+DEPTH_WIDTH-1:0] product
);

  localparam int PROD_W = 16 + DEPTH_WIDTH;
  localparam int CNT_W  = $clog2(DEPTH_WIDTH + 1);

  logic signed [PROD_W-1:0] acc;
  logic signed [PROD_W-1:0] mcandShift;
  logic [DEPTH_WIDTH-1:0]   mplierShift;
  logic [CNT_W-1:0]         stepCnt;
  logic                     running;

  // Each step adds the (progressively left-shifted) multiplicand when the
  // current multiplier LSB is set. The multiplicand is sign-extended to the
  // full product width up front so the accumulation is exact.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      mcandShift  <= '0;
      mplierShift <= '0;
      stepCnt     <= '0;
      running     <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc         <= '0;
        mcandShift  <= PROD_W'(multiplicand);
        mplierShift <= multiplier;
        stepCnt     <= '0;
        running     <= 1'b1;
      end else if (running) begin
        if (mplierShift[0]) begin
          acc <= acc + mcandShift;
        end
        mcandShift  <= mcandShift <<< 1;
        mplierShift <= mplierShift >> 1;
        stepCnt     <= stepCnt + 1'b1;
        if (stepCnt == CNT_W'(DEPTH_WIDTH - 1)) begin
          running <= 1'b0;
          done    <= 1'b1;
        end
      end
    end
  end

  assign product = acc;

endmodule

// File: rtl/lfo_delay_gen.sv
`timescale 1ns/1ps
// lfo_delay_gen
// Triangle LFO producing the signed per-sample delay offset for the
// chorus/flanger delay buffer. Each accepted sample tick advances the phase,
// folds it into a bipolar triangle, scales it by depth with a sequential
// multiplier and presents the result with a one-cycle strobe.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   pktChanged_s_i  : sample tick (one cycle per audio sample)
//   rateInc_s_i     : phase increment per tick
//   depth_s_i       : peak deviation in samples (unsigned)
//   enable_s_i      : 1 = modulate, 0 = offset 0 and phase frozen
//   extraDelay_s_o  : signed delay offset (registered, holds between strobes)
//   LFOChanged_s_o  : one-cycle strobe marking a new extraDelay_s_o
//   errorLED_s_o    : sticky, a tick arrived while busy
//   busyLED_c_o     : high whenever the controller is not IDLE
module lfo_delay_gen
  import dsp_pkg::*;
#(
  parameter int PHASE_WIDTH = 24,
  parameter int ADDR_WIDTH  = 14,
  parameter int DEPTH_WIDTH = 10
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pktChanged_s_i,
  input  logic [PHASE_WIDTH-1:0]        rateInc_s_i,
  input  logic [DEPTH_WIDTH-1:0]        depth_s_i,
  input  logic                          enable_s_i,
  output logic signed [ADDR_WIDTH-1:0]  extraDelay_s_o,
  output logic                          LFOChanged_s_o,
  output logic                          errorLED_s_o,
  output logic                          busyLED_c_o
);

  localparam int PROD_W = 16 + DEPTH_WIDTH;
  localparam int CNT_W  = $clog2(DEPTH_WIDTH + 1);
  localparam logic [PHASE_WIDTH-1:0] PHASE_RESET = PHASE_WIDTH'(1) << (PHASE_WIDTH - 2);
  localparam logic signed [63:0] SAT_MAX = (64'sd1 <<< (ADDR_WIDTH - 1)) - 64'sd1;
  localparam logic signed [63:0] SAT_MIN = -(64'sd1 <<< (ADDR_WIDTH - 1));

  lfo_state_t               state;
  logic [PHASE_WIDTH-1:0]   phase;
  logic [PHASE_WIDTH-1:0]   incLatched;
  logic [DEPTH_WIDTH-1:0]   depthLatched;
  logic                     enableLatched;
  logic [CNT_W-1:0]         multCnt;

  logic [PHASE_WIDTH-1:0]   phaseNext;
  logic [TRI_BITS-1:0]      triVal;
  logic signed [15:0]       biNext;
  logic                     multStart;
  logic                     multDone;
  logic signed [PROD_W-1:0] product;
  logic signed [63:0]       shiftedWide;
  logic signed [ADDR_WIDTH-1:0] satValue;

  // Phase the ADVANCE cycle will commit, and the bipolar triangle derived
  // from it. The multiplier loads this value on the same edge the phase
  // register is updated, so no extra cycle is spent re-reading the phase.
  always_comb begin
    phaseNext = enableLatched ? (phase + incLatched) : phase;
    triVal    = phaseNext[PHASE_WIDTH-2 -: TRI_BITS];
    if (phaseNext[PHASE_WIDTH-1]) begin
      triVal = ~triVal;
    end
    biNext = $signed({1'b0, triVal}) - 16'(TRI_OFFSET);
  end

  assign multStart = (state == ADVANCE);

  lfo_shift_add_mult #(
    .DEPTH_WIDTH (DEPTH_WIDTH)
  ) uMult (
    .clk          (clk),
    .rst          (rst),
    .start        (multStart),
    .multiplicand (biNext),
    .multiplier   (depthLatched),
    .done         (multDone),
    .product      (product)
  );

  // Scale the product back to samples (floor via arithmetic shift) and clamp
  // to the signed offset range. The wide intermediate keeps the comparison
  // valid for any width combination.
  always_comb begin
    shiftedWide = 64'(product) >>> TRI_SHIFT;
    if (shiftedWide > SAT_MAX) begin
      satValue = ADDR_WIDTH'(SAT_MAX);
    end else if (shiftedWide < SAT_MIN) begin
      satValue = ADDR_WIDTH'(SAT_MIN);
    end else begin
      satValue = ADDR_WIDTH'(shiftedWide);
    end
  end

  // Controller: accepts ticks only in IDLE or DONE (back-to-back ticks that
  // land exactly on DONE are not lost), flags ticks that arrive mid-computation,
  // and registers the offset plus strobe while leaving DONE. A disabled tick
  // still runs the sequence so the delay buffer always gets its strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      phase          <= PHASE_RESET;
      incLatched     <= '0;
      depthLatched   <= '0;
      enableLatched  <= 1'b0;
      multCnt        <= '0;
      extraDelay_s_o <= '0;
      LFOChanged_s_o <= 1'b0;
      errorLED_s_o   <= 1'b0;
    end else begin
      LFOChanged_s_o <= 1'b0;
      case (state)
        IDLE: begin
          if (pktChanged_s_i) begin
            incLatched    <= rateInc_s_i;
            depthLatched  <= depth_s_i;
            enableLatched <= enable_s_i;
            state         <= ADVANCE;
          end
        end
        ADVANCE: begin
          if (pktChanged_s_i) begin
            errorLED_s_o <= 1'b1;
          end
          phase   <= phaseNext;
          multCnt <= '0;
          state   <= MULT;
        end
        MULT: begin
          if (pktChanged_s_i) begin
            errorLED_s_o <= 1'b1;
          end
          if (multCnt == CNT_W'(DEPTH_WIDTH - 1)) begin
            state <= DONE;
          end else begin
            multCnt <= multCnt + 1'b1;
          end
        end
        DONE: begin
          if (multDone) begin
            extraDelay_s_o <= enableLatched ? satValue : '0;
            LFOChanged_s_o <= 1'b1;
          end
          if (pktChanged_s_i) begin
            incLatched    <= rateInc_s_i;
            depthLatched  <= depth_s_i;
            enableLatched <= enable_s_i;
            state         <= ADVANCE;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          state        <= IDLE;
          errorLED_s_o <= 1'b1;
        end
      endcase
    end
  end

  assign busyLED_c_o = (state != IDLE);

endmodule

// File: tb/tb_lfo_delay_gen.sv
`timescale 1ns/1ps
// tb_lfo_delay_gen
// Directed self-checking bench for lfo_delay_gen with default parameters.
// Expected offsets are hand-computed from the phase/triangle/depth arithmetic.
module tb_lfo_delay_gen;

  logic               clk;
  logic               rst;
  logic               pktChanged;
  logic [23:0]        rateInc;
  logic [9:0]         depth;
  logic               enable;
  logic signed [13:0] extraDelay;
  logic               lfoChanged;
  logic               errorLed;
  logic               busyLed;

  int assertCount;
  int failCount;

  lfo_delay_gen dut (
    .clk            (clk),
    .rst            (rst),
    .pktChanged_s_i (pktChanged),
    .rateInc_s_i    (rateInc),
    .depth_s_i      (depth),
    .enable_s_i     (enable),
    .extraDelay_s_o (extraDelay),
    .LFOChanged_s_o (lfoChanged),
    .errorLED_s_o   (errorLed),
    .busyLED_c_o    (busyLed)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: counts it, and reports tag/observed/expected on mismatch
  task automatic checkOutput(input string tag, input int observed, input int expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one tick so it is sampled at the next rising edge; returns 1 ns
  // after that edge with the tick removed
  task automatic applyStimulus(input logic [23:0] inc, input logic [9:0] dep, input logic en);
    rateInc    = inc;
    depth      = dep;
    enable     = en;
    pktChanged = 1'b1;
    @(posedge clk);
    #1;
    pktChanged = 1'b0;
  endtask

  // Synchronous reset for one edge, then check all outputs are cleared
  task automatic doReset(input string tag);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput({tag, "_rstDelay"}, int'(extraDelay), 0);
    checkOutput({tag, "_rstStrobe"}, int'(lfoChanged), 0);
    checkOutput({tag, "_rstError"}, int'(errorLed), 0);
    checkOutput({tag, "_rstBusy"}, int'(busyLed), 0);
  endtask

  // Wait (bounded) for the strobe after a tick and check latency and value
  task automatic waitResult(input string tag, input int expected);
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!lfoChanged && n < 40);
    checkOutput({tag, "_latency"}, n, 12);
    checkOutput({tag, "_value"}, int'(extraDelay), expected);
  endtask

  initial begin
    int strobeCnt;
    int firstVal;
    assertCount = 0;
    failCount   = 0;
    rst         = 1'b1;
    pktChanged  = 1'b0;
    rateInc     = '0;
    depth       = '0;
    enable      = 1'b0;

    // Reset and idle: nothing may happen without ticks
    $display("[TB] reset and idle");
    doReset("idle");
    strobeCnt = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (lfoChanged) strobeCnt++;
    end
    checkOutput("idle_strobes", strobeCnt, 0);
    checkOutput("idle_busy", int'(busyLed), 0);
    checkOutput("idle_delay", int'(extraDelay), 0);

    // Single tick: phase 0x440000 -> bi 1024, *512 >>> 14 = 32, exact latency
    $display("[TB] single tick");
    doReset("single");
    applyStimulus(24'h040000, 10'd512, 1'b1);
    checkOutput("single_busy", int'(busyLed), 1);
    repeat (11) @(posedge clk);
    #1;
    checkOutput("single_earlyStrobe", int'(lfoChanged), 0);
    @(posedge clk);
    #1;
    checkOutput("single_strobe", int'(lfoChanged), 1);
    checkOutput("single_value", int'(extraDelay), 32);
    @(posedge clk);
    #1;
    checkOutput("single_strobeOneCycle", int'(lfoChanged), 0);
    checkOutput("single_hold", int'(extraDelay), 32);
    checkOutput("single_idleBusy", int'(busyLed), 0);

    // Quarter-cycle steps at full depth: phases 0x800000, 0xC00000, 0x000000,
    // 0x400000 give bi 16383, -1, -16384, 0 -> 1022, -1, -1023, 0
    $display("[TB] wrap and fold");
    doReset("wrap");
    applyStimulus(24'h400000, 10'd1023, 1'b1);
    waitResult("wrap0", 1022);
    repeat (8) @(posedge clk);
    #1;
    applyStimulus(24'h400000, 10'd1023, 1'b1);
    waitResult("wrap1", -1);
    repeat (8) @(posedge clk);
    #1;
    applyStimulus(24'h400000, 10'd1023, 1'b1);
    waitResult("wrap2", -1023);
    repeat (8) @(posedge clk);
    #1;
    applyStimulus(24'h400000, 10'd1023, 1'b1);
    waitResult("wrap3", 0);

    // Disabled tick strobes with 0 and leaves the phase untouched
    $display("[TB] disabled tick");
    doReset("disable");
    applyStimulus(24'h040000, 10'd1023, 1'b0);
    waitResult("disable", 0);
    repeat (4) @(posedge clk);
    #1;
    applyStimulus(24'h040000, 10'd512, 1'b1);
    waitResult("afterDisable", 32);

    // Depth zero gives zero even with a large bi
    $display("[TB] zero depth");
    doReset("depth0");
    applyStimulus(24'h400000, 10'd0, 1'b1);
    waitResult("depth0", 0);

    // Tick coincident with DONE is accepted: 32 then 64 (phase 0x480000)
    $display("[TB] back-to-back on DONE");
    doReset("b2b");
    applyStimulus(24'h040000, 10'd512, 1'b1);
    repeat (11) @(posedge clk);
    #1;
    applyStimulus(24'h040000, 10'd512, 1'b1);
    checkOutput("b2b_firstStrobe", int'(lfoChanged), 1);
    checkOutput("b2b_firstValue", int'(extraDelay), 32);
    checkOutput("b2b_busy", int'(busyLed), 1);
    waitResult("b2b_second", 64);
    checkOutput("b2b_noError", int'(errorLed), 0);

    // Tick during MULT is dropped and flags a sticky error
    $display("[TB] overrun");
    doReset("overrun");
    applyStimulus(24'h040000, 10'd512, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    applyStimulus(24'h400000, 10'd1023, 1'b1);
    strobeCnt = 0;
    firstVal  = 9999;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (lfoChanged) begin
        if (strobeCnt == 0) firstVal = int'(extraDelay);
        strobeCnt++;
      end
    end
    checkOutput("overrun_strobes", strobeCnt, 1);
    checkOutput("overrun_value", firstVal, 32);
    checkOutput("overrun_error", int'(errorLed), 1);
    applyStimulus(24'h040000, 10'd512, 1'b1);
    waitResult("overrun_next", 64);
    checkOutput("overrun_errorSticky", int'(errorLed), 1);
    doReset("overrunClear");

    // Reset during MULT aborts without a strobe and restarts from reset phase
    $display("[TB] reset mid-operation");
    applyStimulus(24'h040000, 10'd512, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    doReset("abort");
    strobeCnt = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (lfoChanged) strobeCnt++;
    end
    checkOutput("abort_strobes", strobeCnt, 0);
    checkOutput("abort_delay", int'(extraDelay), 0);
    applyStimulus(24'h040000, 10'd512, 1'b1);
    waitResult("abort_next", 32);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
